// File: rtl/car_park_pkg.sv
// rtl/car_park_pkg.sv - shared state encodings and defaults for the car-park gate controllers
package car_park_pkg;

    // 3-bit encoding shared with the entry-side controller
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_TICKET = 3'd1,
        ST_BAD_TICKET  = 3'd2,
        ST_OPEN        = 3'd3
    } gate_state_t;

    localparam int         DEFAULT_CAPACITY    = 8;
    localparam int         DEFAULT_CNT_W       = 4;
    localparam logic [1:0] DEFAULT_EXIT_CODE   = 2'b10;
    localparam int         DEFAULT_TICKET_WAIT = 16;

endpackage

// File: rtl/car_occupancy_counter.sv
// rtl/car_occupancy_counter.sv - saturating lot occupancy counter with over/underflow flagging
import car_park_pkg::*;

module car_occupancy_counter #(
    parameter int CAPACITY = DEFAULT_CAPACITY,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             err
);

    assign full  = (count == CNT_W'(CAPACITY));
    assign empty = (count == '0);

    // A simultaneous inc and dec cancel: no change and no error even when full
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            err <= inc & ~dec & full;
            if (inc & ~dec & ~full) begin
                count <= count + CNT_W'(1);
            end else if (dec & ~inc & ~empty) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/car_exit_gate.sv
// rtl/car_exit_gate.sv - exit barrier controller: ticket check, barrier/LED drive, occupancy tracking
import car_park_pkg::*;

module car_exit_gate #(
    parameter int         CAPACITY    = DEFAULT_CAPACITY,
    parameter int         CNT_W       = DEFAULT_CNT_W,
    parameter logic [1:0] EXIT_CODE   = DEFAULT_EXIT_CODE,
    parameter int         TICKET_WAIT = DEFAULT_TICKET_WAIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_grant,
    input  logic             exit_sensor,
    input  logic             exit_clear,
    input  logic             ticket_valid,
    input  logic [1:0]       ticket_code,
    output logic             GATE_OPEN,
    output logic             GREEN_LED,
    output logic             RED_LED,
    output logic [CNT_W-1:0] occupancy,
    output logic             lot_full,
    output logic             lot_empty,
    output logic             err_pulse
);

    localparam int WAIT_W = (TICKET_WAIT > 1) ? $clog2(TICKET_WAIT) : 1;

    gate_state_t       state, state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              blink;
    logic              exit_done;
    logic              empty_err;
    logic              cnt_err;

    assign exit_done = (state == ST_OPEN) & exit_clear;
    assign err_pulse = cnt_err | empty_err;

    car_occupancy_counter #(
        .CAPACITY (CAPACITY),
        .CNT_W    (CNT_W)
    ) u_occupancy (
        .clk   (clk),
        .reset (reset),
        .inc   (entry_grant),
        .dec   (exit_done),
        .count (occupancy),
        .full  (lot_full),
        .empty (lot_empty),
        .err   (cnt_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (exit_sensor & ~lot_empty) state_next = ST_WAIT_TICKET;
            end
            ST_WAIT_TICKET: begin
                // ticket beats the car backing off, which beats the timeout
                if (ticket_valid) begin
                    state_next = (ticket_code == EXIT_CODE) ? ST_OPEN : ST_BAD_TICKET;
                end else if (!exit_sensor) begin
                    state_next = ST_IDLE;
                end else if (wait_cnt == WAIT_W'(TICKET_WAIT - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_BAD_TICKET: begin
                if (ticket_valid && (ticket_code == EXIT_CODE)) begin
                    state_next = ST_OPEN;
                end else if (!exit_sensor) begin
                    state_next = ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (exit_clear) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT_TICKET) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Indicators lag the state by one cycle; blink restarts so RED begins high in BAD_TICKET
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            GATE_OPEN <= 1'b0;
            GREEN_LED <= 1'b0;
            RED_LED   <= 1'b0;
            blink     <= 1'b0;
            empty_err <= 1'b0;
        end else begin
            GATE_OPEN <= (state == ST_OPEN);
            GREEN_LED <= (state == ST_OPEN);
            RED_LED   <= (state == ST_WAIT_TICKET) | ((state == ST_BAD_TICKET) & ~blink);
            blink     <= (state == ST_BAD_TICKET) ? ~blink : 1'b0;
            empty_err <= (state == ST_IDLE) & exit_sensor & lot_empty;
        end
    end

endmodule

// File: tb/tb_car_exit_gate.sv
// tb/tb_car_exit_gate.sv - directed and randomized self-checking bench for car_exit_gate
module tb_car_exit_gate;

    localparam int         CAP  = 8;
    localparam int         TW   = 16;
    localparam logic [1:0] CODE = 2'b10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       entry_grant = 1'b0;
    logic       exit_sensor = 1'b0;
    logic       exit_clear = 1'b0;
    logic       ticket_valid = 1'b0;
    logic [1:0] ticket_code = 2'b00;
    logic       GATE_OPEN, GREEN_LED, RED_LED, lot_full, lot_empty, err_pulse;
    logic [3:0] occupancy;

    car_exit_gate #(
        .CAPACITY    (CAP),
        .CNT_W       (4),
        .EXIT_CODE   (CODE),
        .TICKET_WAIT (TW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .entry_grant  (entry_grant),
        .exit_sensor  (exit_sensor),
        .exit_clear   (exit_clear),
        .ticket_valid (ticket_valid),
        .ticket_code  (ticket_code),
        .GATE_OPEN    (GATE_OPEN),
        .GREEN_LED    (GREEN_LED),
        .RED_LED      (RED_LED),
        .occupancy    (occupancy),
        .lot_full     (lot_full),
        .lot_empty    (lot_empty),
        .err_pulse    (err_pulse)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference: mode 0 idle, 1 awaiting ticket, 2 ticket rejected, 3 barrier open
    int m_mode, m_wait, m_bad, m_occ;
    int e_gate, e_green, e_red, e_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_wait = 0; m_bad = 0; m_occ = 0;
        e_gate = 0; e_green = 0; e_red = 0; e_err = 0;
    endtask

    task automatic model_edge();
        int done;
        int occ_next;
        if (reset) begin
            model_reset();
            return;
        end
        done    = (m_mode == 3 && exit_clear) ? 1 : 0;
        e_gate  = (m_mode == 3) ? 1 : 0;
        e_green = (m_mode == 3) ? 1 : 0;
        e_red   = (m_mode == 1 || (m_mode == 2 && m_bad % 2 == 0)) ? 1 : 0;
        e_err   = ((m_mode == 0 && exit_sensor && m_occ == 0) ||
                   (entry_grant && done == 0 && m_occ == CAP)) ? 1 : 0;
        case (m_mode)
            0: if (exit_sensor && m_occ != 0) begin m_mode = 1; m_wait = 0; end
            1: begin
                m_wait++;
                if (ticket_valid) begin
                    m_mode = (ticket_code == CODE) ? 3 : 2;
                    m_bad  = 0;
                end else if (!exit_sensor) m_mode = 0;
                else if (m_wait == TW) m_mode = 0;
            end
            2: begin
                m_bad++;
                if (ticket_valid && ticket_code == CODE) m_mode = 3;
                else if (!exit_sensor) m_mode = 0;
            end
            default: if (exit_clear) m_mode = 0;
        endcase
        occ_next = m_occ + (entry_grant ? 1 : 0) - done;
        if (occ_next > CAP) occ_next = CAP;
        if (occ_next < 0) occ_next = 0;
        m_occ = occ_next;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".occ"},   occupancy, m_occ);
        chk({tag, ".full"},  lot_full,  (m_occ == CAP) ? 1 : 0);
        chk({tag, ".empty"}, lot_empty, (m_occ == 0) ? 1 : 0);
        chk({tag, ".gate"},  GATE_OPEN, e_gate);
        chk({tag, ".green"}, GREEN_LED, e_green);
        chk({tag, ".red"},   RED_LED,   e_red);
        chk({tag, ".err"},   err_pulse, e_err);
    endtask

    task automatic step(input string tag, input logic g, input logic s, input logic c,
                        input logic tv, input logic [1:0] code);
        entry_grant = g; exit_sensor = s; exit_clear = c; ticket_valid = tv; ticket_code = code;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        step("rst", 0, 0, 0, 0, 2'b00);
        step("rst", 0, 0, 0, 0, 2'b00);
        chk("rst.empty_const", lot_empty, 1);
        reset = 1'b0;

        // three cars in, one out through a good ticket
        for (int i = 0; i < 3; i++) begin
            step("t2.grant", 1, 0, 0, 0, 2'b00);
            step("t2.gap", 0, 0, 0, 0, 2'b00);
        end
        step("t2.sense", 0, 1, 0, 0, 2'b00);
        step("t2.ticket", 0, 1, 0, 1, 2'b10);
        step("t2.open", 0, 1, 0, 0, 2'b00);
        step("t2.open", 0, 1, 0, 0, 2'b00);
        chk("t2.green_const", GREEN_LED, 1);
        step("t2.clear", 0, 0, 1, 0, 2'b00);
        step("t2.idle", 0, 0, 0, 0, 2'b00);
        chk("t2.occ_const", occupancy, 2);

        // rejected ticket blinks RED, then the right ticket opens
        step("t3.sense", 0, 1, 0, 0, 2'b00);
        step("t3.badtk", 0, 1, 0, 1, 2'b01);
        for (int i = 0; i < 5; i++) step("t3.blink", 0, 1, 0, 0, 2'b00);
        step("t3.goodtk", 0, 1, 0, 1, 2'b10);
        step("t3.open", 0, 1, 0, 0, 2'b00);
        chk("t3.gate_const", GATE_OPEN, 1);
        step("t3.clear", 0, 0, 1, 0, 2'b00);
        step("t3.idle", 0, 0, 0, 0, 2'b00);

        // ticket timeout with the car still waiting
        for (int i = 0; i < 17; i++) step("t4.wait", 0, 1, 0, 0, 2'b00);
        step("t4.drop", 0, 0, 0, 0, 2'b00);
        step("t4.idle", 0, 0, 0, 0, 2'b00);
        chk("t4.occ_const", occupancy, 1);

        // fill the lot, overflow attempt, then grant coincident with an exit
        for (int i = 0; i < 7; i++) step("t5.fill", 1, 0, 0, 0, 2'b00);
        step("t5.over", 1, 0, 0, 0, 2'b00);
        chk("t5.err_const", err_pulse, 1);
        step("t5.quiet", 0, 0, 0, 0, 2'b00);
        chk("t5.err_gone", err_pulse, 0);
        step("t5.sense", 0, 1, 0, 0, 2'b00);
        step("t5.ticket", 0, 1, 0, 1, 2'b10);
        step("t5.open", 0, 1, 0, 0, 2'b00);
        step("t5.swap", 1, 0, 1, 0, 2'b00);
        chk("t5.occ_const", occupancy, 8);
        step("t5.idle", 0, 0, 0, 0, 2'b00);

        // reset while the barrier is open
        step("t1.sense", 0, 1, 0, 0, 2'b00);
        step("t1.ticket", 0, 1, 0, 1, 2'b10);
        step("t1.open", 0, 1, 0, 0, 2'b00);
        reset = 1'b1;
        model_reset();
        #1;
        chk("t1.gate_async", GATE_OPEN, 0);
        chk("t1.occ_async", occupancy, 0);
        chk("t1.empty_async", lot_empty, 1);
        step("t1.held", 0, 1, 0, 0, 2'b00);
        step("t1.held", 0, 1, 0, 0, 2'b00);
        reset = 1'b0;

        // exit request on an empty lot
        for (int i = 0; i < 3; i++) step("t6.empty", 0, 1, 0, 0, 2'b00);
        chk("t6.err_const", err_pulse, 1);
        chk("t6.gate_const", GATE_OPEN, 0);
        step("t6.idle", 0, 0, 0, 0, 2'b00);

        // randomized traffic against the reference
        for (int i = 0; i < 600; i++) begin
            step("rnd",
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0),
                 2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
